pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the pipelined CPU core. Collects per-stage stall and flush requests, IO-confirmation waits and single-step requests, and drives per-stage stall and flush vectors to the inter-stage pipeline registers (IF_ID, ID_EXE and the later stage registers). It generalises the fixed-stage controller to STAGES stages and IO_CH IO-wait channels, and adds flush handling, a registered wait/step state machine and optional performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_prio_onehot.sv | 31 +++
 rtl/pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - ctrl_state_e : wait/step state machine encodings (RUN/IO_WAIT/IO_DONE/HALT)
//   - CTRL_STATE_W : width of the ctrl_state port
//   - DEF_STAGES   : default number of pipeline stages (IF .. WB)
//   - DEF_IO_CH    : default number of IO-wait channels
//   - DEF_CNT_W    : default performance counter width
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int CTRL_STATE_W = 2;
  localparam int DEF_STAGES   = 5;
  localparam int DEF_IO_CH    = 2;
  localparam int DEF_CNT_W    = 32;

  typedef enum logic [CTRL_STATE_W-1:0] {
    RUN     = 2'd0,
    IO_WAIT = 2'd1,
    IO_DONE = 2'd2,
    HALT    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_prio_onehot.sv
// -----------------------------------------------------------------------------
// prio_onehot
// Lowest-index one-hot picker. Feed it a bit-reversed vector (and reverse the
// result) to obtain a highest-index picker.
// Ports:
//   req   in  W  request vector
//   grant out W  one-hot of the lowest set bit of req, 0 when req == 0
// -----------------------------------------------------------------------------
module prio_onehot #(
  parameter int W = 2
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] grant
);

  logic [W-1:0] grant_s;

  // Scan upward; a bit is granted only if no lower bit has been seen yet.
  always_comb begin
    logic seen_s;
    seen_s  = 1'b0;
    grant_s = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      grant_s[i] = req[i] & ~seen_s;
      seen_s     = seen_s | req[i];
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard controller. Merges per-stage stall/flush requests, IO
// confirmation waits and single-step requests into per-stage stall and flush
// vectors for the inter-stage pipeline registers (IF_ID, ID_EXE, ...).
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   : cycle/stall/flush performance counters (saturating)
//   undefined : counter ports tied to 0, no counter flops
//
// Ports:
//   clk        in   1       core clock
//   rst_n      in   1       asynchronous active-low reset
//   stall_req  in   STAGES  stage i cannot complete this cycle
//   flush_req  in   STAGES  stage i redirects the PC, kills stages 0..i-1
//   io_req     in   IO_CH   channel c waits for user confirmation (level)
//   io_ack     in   IO_CH   one-cycle confirm pulse for channel c
//   step_mode  in   1       single-step mode enable
//   step       in   1       one-cycle advance pulse in step mode
//   stall      out  STAGES  stage register holds
//   flush      out  STAGES  stage register loads a bubble
//   io_grant   out  IO_CH   one-hot channel being waited on (registered)
//   ctrl_state out  2       state machine encoding (registered)
//   cycle_cnt, stall_cnt, flush_cnt  out CNT_W  performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int IO_CH  = DEF_IO_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush_req,
  input  logic [IO_CH-1:0]        io_req,
  input  logic [IO_CH-1:0]        io_ack,
  input  logic                    step_mode,
  input  logic                    step,
  output logic [STAGES-1:0]       stall,
  output logic [STAGES-1:0]       flush,
  output logic [IO_CH-1:0]        io_grant,
  output logic [CTRL_STATE_W-1:0] ctrl_state,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  ctrl_state_e       state_r;
  logic [IO_CH-1:0]  grant_r;

  logic [IO_CH-1:0]  io_pick_s;
  logic              io_any_s;

  logic [STAGES-1:0] stall_rev_s;
  logic [STAGES-1:0] flush_rev_s;
  logic [STAGES-1:0] stall_rev_pick_s;
  logic [STAGES-1:0] flush_rev_pick_s;
  logic [STAGES-1:0] stall_hi_s;
  logic [STAGES-1:0] flush_hi_s;

  logic [STAGES-1:0] rule_stall_s;
  logic [STAGES-1:0] rule_flush_s;
  logic              adv_s;
  logic [STAGES-1:0] stall_s;
  logic [STAGES-1:0] flush_s;

  // ---------------------------------------------------------------------------
  // Priority pickers: lowest IO channel, highest stalling / flushing stage
  // ---------------------------------------------------------------------------
  prio_onehot #(.W(IO_CH)) u_io_pick (
    .req   (io_req),
    .grant (io_pick_s)
  );

  assign io_any_s = |io_req;

  for (genvar g = 0; g < STAGES; g++) begin : g_rev
    assign stall_rev_s[g] = stall_req[STAGES-1-g];
    assign flush_rev_s[g] = flush_req[STAGES-1-g];
    assign stall_hi_s[g]  = stall_rev_pick_s[STAGES-1-g];
    assign flush_hi_s[g]  = flush_rev_pick_s[STAGES-1-g];
  end

  prio_onehot #(.W(STAGES)) u_stall_pick (
    .req   (stall_rev_s),
    .grant (stall_rev_pick_s)
  );

  prio_onehot #(.W(STAGES)) u_flush_pick (
    .req   (flush_rev_s),
    .grant (flush_rev_pick_s)
  );

  // ---------------------------------------------------------------------------
  // Local stall + flush rules: stages at/below the oldest staller hold, the
  // stage just above it takes a bubble; stages younger than the oldest
  // flusher are killed (bubble, no hold) regardless of local stalls.
  // ---------------------------------------------------------------------------
  // Build the advancing-cycle stall/flush vectors from the picked stages.
  always_comb begin
    logic at_or_below_k_s;
    logic below_j_s;
    at_or_below_k_s = 1'b0;
    below_j_s       = 1'b0;
    rule_stall_s    = {STAGES{1'b0}};
    rule_flush_s    = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      at_or_below_k_s = at_or_below_k_s | stall_hi_s[i];
      if (below_j_s) begin
        rule_stall_s[i] = 1'b0;
        rule_flush_s[i] = 1'b1;
      end else begin
        rule_stall_s[i] = at_or_below_k_s;
        rule_flush_s[i] = (i > 0) ? stall_hi_s[i-1] : 1'b0;
      end
      below_j_s = below_j_s | flush_hi_s[i];
    end
  end

  // Decide whether this cycle advances (rules apply) or globally stalls.
  always_comb begin
    case (state_r)
      RUN:     adv_s = ~io_any_s & ~step_mode;
      IO_WAIT: adv_s = 1'b0;
      IO_DONE: adv_s = 1'b1;
      HALT:    adv_s = step & ~io_any_s;
      default: adv_s = 1'b0;
    endcase
  end

  // Global stall overrides both rules whenever the cycle does not advance.
  always_comb begin
    if (adv_s) begin
      stall_s = rule_stall_s;
      flush_s = rule_flush_s;
    end else begin
      stall_s = {STAGES{1'b1}};
      flush_s = {STAGES{1'b0}};
    end
  end

  assign stall = stall_s;
  assign flush = flush_s;

  // ---------------------------------------------------------------------------
  // Wait/step state machine with registered grant
  // ---------------------------------------------------------------------------
  // IO requests win over step mode; IO_DONE ignores io_req so the released
  // channel gets its one advancing cycle before any re-arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      grant_r <= {IO_CH{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (io_any_s) begin
            grant_r <= io_pick_s;
            state_r <= IO_WAIT;
          end else if (step_mode) begin
            grant_r <= {IO_CH{1'b0}};
            state_r <= HALT;
          end else begin
            grant_r <= {IO_CH{1'b0}};
            state_r <= RUN;
          end
        end
        IO_WAIT: begin
          if (|(io_ack & grant_r)) begin
            grant_r <= grant_r;
            state_r <= IO_DONE;
          end else if (~|(io_req & grant_r)) begin
            grant_r <= {IO_CH{1'b0}};
            state_r <= RUN;
          end else begin
            grant_r <= grant_r;
            state_r <= IO_WAIT;
          end
        end
        IO_DONE: begin
          grant_r <= {IO_CH{1'b0}};
          state_r <= step_mode ? HALT : RUN;
        end
        HALT: begin
          if (io_any_s) begin
            grant_r <= io_pick_s;
            state_r <= IO_WAIT;
          end else if (!step_mode) begin
            grant_r <= {IO_CH{1'b0}};
            state_r <= RUN;
          end else begin
            grant_r <= {IO_CH{1'b0}};
            state_r <= HALT;
          end
        end
        default: begin
          grant_r <= {IO_CH{1'b0}};
          state_r <= RUN;
        end
      endcase
    end
  end

  assign io_grant   = grant_r;
  assign ctrl_state = state_r;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             flush_hon_s;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A flush request only counts when the cycle advances (not globally stalled).
  assign flush_hon_s = adv_s & (|flush_req);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (cycle_cnt_r != CNT_MAX) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (stall_s[0] && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_hon_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign cycle_cnt = {CNT_W{1'b0}};
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (STAGES=5, IO_CH=2, CNT_W=32). A
// behavioural model tracks the controller mode and counters; outputs are
// compared against it every falling edge, and directed vectors carry
// hand-computed literal expectations. Counter expectations follow
// PIPE_CTRL_PERF_EN.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int S = 5;
  localparam int C = 2;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [S-1:0] stall_req = '0;
  logic [S-1:0] flush_req = '0;
  logic [C-1:0] io_req = '0;
  logic [C-1:0] io_ack = '0;
  logic         step_mode = 1'b0;
  logic         step = 1'b0;
  logic [S-1:0] stall;
  logic [S-1:0] flush;
  logic [C-1:0] io_grant;
  logic [1:0]   ctrl_state;
  logic [W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  pipe_ctrl #(.STAGES(S), .IO_CH(C), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_req  (stall_req),
    .flush_req  (flush_req),
    .io_req     (io_req),
    .io_ack     (io_ack),
    .step_mode  (step_mode),
    .step       (step),
    .stall      (stall),
    .flush      (flush),
    .io_grant   (io_grant),
    .ctrl_state (ctrl_state),
    .cycle_cnt  (cycle_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int M_RUN = 0, M_WAIT = 1, M_DONE = 2, M_HALT = 3;

  int           m_st;
  logic [C-1:0] m_grant;
  logic [W-1:0] m_cyc, m_stl, m_fls;
  logic [S-1:0] e_stall, e_flush;
  logic         e_adv;

  function automatic logic [C-1:0] lowest(input logic [C-1:0] v);
    logic [C-1:0] r;
    r = '0;
    for (int c = C - 1; c >= 0; c--) if (v[c]) r = C'(1) << c;
    return r;
  endfunction

  // Expected stall/flush: search oldest staller k and oldest flusher j.
  always_comb begin
    int k, j;
    case (m_st)
      M_RUN:   e_adv = (io_req == '0) && !step_mode;
      M_DONE:  e_adv = 1'b1;
      M_HALT:  e_adv = step && (io_req == '0);
      default: e_adv = 1'b0;
    endcase
    k = -1;
    j = -1;
    for (int i = 0; i < S; i++) begin
      if (stall_req[i]) k = i;
      if (flush_req[i]) j = i;
    end
    e_stall = '0;
    e_flush = '0;
    if (!e_adv) begin
      e_stall = '1;
    end else begin
      for (int i = 0; i < S; i++) begin
        if (i < j) e_flush[i] = 1'b1;
        else begin
          if (i <= k) e_stall[i] = 1'b1;
          if (k >= 0 && i == k + 1) e_flush[i] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st    <= M_RUN;
      m_grant <= '0;
      m_cyc   <= '0;
      m_stl   <= '0;
      m_fls   <= '0;
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      m_cyc <= m_cyc + 1;
      if (e_stall[0]) m_stl <= m_stl + 1;
      if (e_adv && flush_req != '0) m_fls <= m_fls + 1;
`endif
      case (m_st)
        M_RUN:
          if (io_req != '0) begin m_grant <= lowest(io_req); m_st <= M_WAIT; end
          else if (step_mode) m_st <= M_HALT;
        M_WAIT:
          if ((io_ack & m_grant) != '0) m_st <= M_DONE;
          else if ((io_req & m_grant) == '0) begin m_st <= M_RUN; m_grant <= '0; end
        M_DONE: begin
          m_grant <= '0;
          m_st    <= step_mode ? M_HALT : M_RUN;
        end
        default:
          if (io_req != '0) begin m_grant <= lowest(io_req); m_st <= M_WAIT; end
          else if (!step_mode) m_st <= M_RUN;
      endcase
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    chk("stall", stall, e_stall);
    chk("flush", flush, e_flush);
    chk("io_grant", io_grant, m_grant);
    chk("ctrl_state", ctrl_state, m_st[1:0]);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("stall_cnt", stall_cnt, m_stl);
    chk("flush_cnt", flush_cnt, m_fls);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string name, input logic [S-1:0] sr, input logic [S-1:0] fr,
                     input logic [S-1:0] es, input logic [S-1:0] ef);
    stall_req = sr;
    flush_req = fr;
    @(negedge clk);
    chk({name, "_stall"}, stall, es);
    chk({name, "_flush"}, flush, ef);
    tick();
  endtask

  initial begin
    int zeros;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 5'b00000);
    chk("rst_flush", flush, 5'b00000);
    chk("rst_state", ctrl_state, 2'd0);
    chk("rst_grant", io_grant, 2'b00);
    tick();
    rst_n = 1'b1;

    // Counters: 10 cycles, 4 stalled at stage 0, 1 flush.
    for (int i = 0; i < 10; i++) begin
      stall_req = (i < 4) ? 5'b00001 : 5'b00000;
      flush_req = (i == 4) ? 5'b00010 : 5'b00000;
      tick();
    end
    stall_req = '0;
    flush_req = '0;
    @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
    chk("cnt_cycle", cycle_cnt, 32'd10);
    chk("cnt_stall", stall_cnt, 32'd4);
    chk("cnt_flush", flush_cnt, 32'd1);
`else
    chk("cnt_cycle", cycle_cnt, 32'd0);
    chk("cnt_stall", stall_cnt, 32'd0);
    chk("cnt_flush", flush_cnt, 32'd0);
`endif
    tick();

    // Local stall / flush rules.
    vec("local",     5'b00010, 5'b00000, 5'b00011, 5'b00100);
    vec("stl_fls",   5'b00010, 5'b01000, 5'b00000, 5'b00111);
    vec("stall_wb",  5'b10000, 5'b00000, 5'b11111, 5'b00000);
    vec("flush_if",  5'b00000, 5'b00001, 5'b00000, 5'b00000);
    vec("mix",       5'b01000, 5'b00100, 5'b01100, 5'b10011);
    vec("idle",      5'b00000, 5'b00000, 5'b00000, 5'b00000);

    // IO wait with two channels requesting.
    io_req = 2'b11;
    @(negedge clk);
    chk("io_stall", stall, 5'b11111);
    tick();
    chk("io_grant1", io_grant, 2'b01);
    chk("io_state1", ctrl_state, 2'd1);
    io_ack = 2'b10;
    tick();
    io_ack = 2'b00;
    chk("io_wrong_ack", ctrl_state, 2'd1);
    io_ack = 2'b01;
    tick();
    io_ack = 2'b00;
    chk("io_done_state", ctrl_state, 2'd2);
    @(negedge clk);
    chk("io_done_stall", stall, 5'b00000);
    tick();
    chk("io_back_run", ctrl_state, 2'd0);
    chk("io_grant_clr", io_grant, 2'b00);
    tick();
    chk("io_regrant", io_grant, 2'b01);
    io_req = 2'b10;
    tick();
    chk("io_drop_state", ctrl_state, 2'd0);
    tick();
    chk("io_grant_ch1", io_grant, 2'b10);
    io_req = 2'b00;
    tick();
    chk("io_cancel", ctrl_state, 2'd0);

    // Single-step mode.
    step_mode = 1'b1;
    @(negedge clk);
    chk("halt_entry_stall", stall, 5'b11111);
    tick();
    chk("halt_state", ctrl_state, 2'd3);
    zeros = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      if (stall == 5'b00000) zeros++;
      tick();
      step = 1'b0;
      @(negedge clk);
      if (stall == 5'b00000) zeros++;
      tick();
    end
    chk("step_advances", zeros, 3);
    step_mode = 1'b0;
    tick();
    chk("step_exit", ctrl_state, 2'd0);

    // IO request inside HALT, release returns to HALT.
    step_mode = 1'b1;
    tick();
    io_req = 2'b01;
    tick();
    chk("halt_io_state", ctrl_state, 2'd1);
    chk("halt_io_grant", io_grant, 2'b01);
    io_ack = 2'b01;
    tick();
    io_ack = 2'b00;
    io_req = 2'b00;
    chk("halt_io_done", ctrl_state, 2'd2);
    tick();
    chk("done_to_halt", ctrl_state, 2'd3);
    step_mode = 1'b0;
    tick();
    chk("halt_to_run", ctrl_state, 2'd0);

    // Asynchronous reset in the middle of a wait.
    io_req = 2'b01;
    tick();
    chk("prerst_state", ctrl_state, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", ctrl_state, 2'd0);
    chk("arst_grant", io_grant, 2'b00);
    io_req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", ctrl_state, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
